// File: rtl/alu_pkg.sv
// Shared encodings for alu_seq: base alucontrol codes, M-extension funct3 codes and the sequencer FSM states.
// Pure declarations; no latency or flow control of its own.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } state_t;

  // funct3[2] separates the divide/remainder group from the multiplies.
  function automatic logic md_is_div(input logic [2:0] f);
    return f[2];
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative M-extension datapath: radix-2 shift-add multiply or restoring divide, one bit per run cycle, XLEN steps.
// No flow control: operands latch on start, result is combinational from the final state and holds until the next start.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            run,
  input  logic [2:0]      fn3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] result
);

  logic [2:0]        fn3_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [SHW-1:0]    cnt;
  logic              neg_main;
  logic              neg_rem;

  logic              sa;
  logic              sb;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_diff;
  logic              rem_ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  always_comb begin
    if (md_is_div(fn3)) begin
      sa = ~fn3[0];
      sb = ~fn3[0];
    end else begin
      sa = (fn3 == MD_MULH) | (fn3 == MD_MULHSU);
      sb = (fn3 == MD_MULH);
    end
    a_neg = sa & a[XLEN-1];
    b_neg = sb & b[XLEN-1];
    abs_a = a_neg ? -a : a;
    abs_b = b_neg ? -b : b;
  end

  // acc holds {high product, shifting multiplier} or {partial remainder, shifting dividend/quotient}.
  always_comb begin
    add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    rem_ge   = (rem_sh >= {1'b0, opnd});
    rem_diff = rem_sh[XLEN-1:0] - opnd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fn3_q    <= '0;
      acc      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (start) begin
      fn3_q <= fn3;
      cnt   <= '0;
      if (md_is_div(fn3)) begin
        acc      <= {{XLEN{1'b0}}, abs_a};
        opnd     <= abs_b;
        // A zero divisor must leave the all-ones quotient unsigned-looking.
        neg_main <= (a_neg ^ b_neg) & (b != '0);
        neg_rem  <= a_neg;
      end else begin
        acc      <= {{XLEN{1'b0}}, abs_b};
        opnd     <= abs_a;
        neg_main <= a_neg ^ b_neg;
        neg_rem  <= 1'b0;
      end
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (md_is_div(fn3_q)) begin
        if (rem_ge) acc <= {rem_diff, acc[XLEN-2:0], 1'b1};
        else        acc <= {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
        acc <= {add_sum, acc[XLEN-1:1]};
      end
    end
  end

  assign last = run & (cnt == SHW'(XLEN-1));

  always_comb begin
    prod = neg_main ? -acc : acc;
    quo  = neg_main ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (fn3_q)
      MD_MUL:                      result = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             result = quo;
      MD_REM, MD_REMU:             result = rem;
      default:                     result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Execute-stage ALU: base ops latency 1 (1/cycle), M ops latency XLEN+2; valid/ready in, valid/ready out, result held under backpressure.
// Option ALU_ZERO_BYPASS_EN: M ops with a zero multiply operand or zero divisor finish with latency 1.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_o
);

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic            consume;
  logic            is_m;
  logic            byp;
  logic            ready_en;
  logic            md_start;
  logic            md_run;
  logic            md_last;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res;
  logic [XLEN-1:0] byp_res;
  logic [XLEN-1:0] fast_res;
  logic [XLEN-1:0] md_res;

  assign is_m    = op_i[4];
  assign accept  = in_valid_i & in_ready_o;
  assign consume = out_valid_o & out_ready_i;
  assign shamt   = b_i[SHW-1:0];

  always_comb begin
    base_res = '0;
    case (op_i[3:0])
      ALU_ADD:  base_res = a_i + b_i;
      ALU_SUB:  base_res = a_i - b_i;
      ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      ALU_AND:  base_res = a_i & b_i;
      ALU_OR:   base_res = a_i | b_i;
      ALU_XOR:  base_res = a_i ^ b_i;
      ALU_SLL:  base_res = a_i << shamt;
      ALU_SRL:  base_res = a_i >> shamt;
      ALU_SRA:  base_res = $signed(a_i) >>> shamt;
      default:  base_res = '0;
    endcase
  end

`ifdef ALU_ZERO_BYPASS_EN
  assign byp     = is_m & (md_is_div(op_i[2:0]) ? (b_i == '0) : ((a_i == '0) | (b_i == '0)));
  assign byp_res = md_is_div(op_i[2:0]) ? (op_i[1] ? a_i : {XLEN{1'b1}}) : '0;
`else
  assign byp     = 1'b0;
  assign byp_res = '0;
`endif

  assign fast_res = is_m ? byp_res : base_res;
  assign md_start = accept & is_m & ~byp;

  // Keeps in_ready_o low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (md_start) state_nxt = md_is_div(op_i[2:0]) ? DIV : MUL;
      MUL, DIV: if (md_last) state_nxt = FIN;
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o = ready_en & (state == IDLE) & (~out_valid_o | out_ready_i);
    md_run     = (state == MUL) | (state == DIV);
  end

  alu_muldiv #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .run    (md_run),
    .fn3    (op_i[2:0]),
    .a      (a_i),
    .b      (b_i),
    .last   (md_last),
    .result (md_res)
  );

  // FIN only follows an accept that drained the output, so it never overwrites a pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o <= 1'b0;
      out_o       <= '0;
    end else if (state == FIN) begin
      out_valid_o <= 1'b1;
      out_o       <= md_res;
    end else if (accept && (!is_m || byp)) begin
      out_valid_o <= 1'b1;
      out_o       <= fast_res;
    end else if (consume) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule
